// File: rtl/cam_pwr_seq.sv
// cam_pwr_seq: ordered camera supply-rail sequencer with PWDN/reset release and reverse power-down.
// Define CAM_PWR_SEQ_PG_CHECK_EN to enable power-good wait, timeout and loss supervision.
module cam_pwr_seq #(
  parameter int CLK_FREQ      = 74_250_000,
  parameter int RAILS         = 3,
  parameter int STEP_US       = 1000,
  parameter int RST_HOLD_US   = 5000,
  parameter int PG_TIMEOUT_US = 10000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [RAILS-1:0] pg_i,
  output logic [RAILS-1:0] rail_en_o,
  output logic             cam_pwdn_o,
  output logic             cam_rst_n_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [2:0]       state_o
);

  localparam int TICKS_PER_US = CLK_FREQ / 1_000_000;
  localparam int STEP_T = TICKS_PER_US * STEP_US;
  localparam int HOLD_T = TICKS_PER_US * RST_HOLD_US;
  localparam int TMO_T  = TICKS_PER_US * PG_TIMEOUT_US;
  localparam int MAX_T  = (STEP_T > HOLD_T) ? ((STEP_T > TMO_T) ? STEP_T : TMO_T)
                                            : ((HOLD_T > TMO_T) ? HOLD_T : TMO_T);
  localparam int CNT_W  = (MAX_T > 0) ? $clog2(MAX_T + 1) : 1;
  localparam int IDX_W  = (RAILS > 1) ? $clog2(RAILS) : 1;

  // Each delay dwells N cycles (cnt 0..N-1); a zero-tick delay still takes one cycle.
  localparam logic [CNT_W-1:0] STEP_LAST = (STEP_T > 0) ? CNT_W'(STEP_T - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_T > 0) ? CNT_W'(HOLD_T - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RAILS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RAIL_ON     = 3'd1,
    RAIL_SETTLE = 3'd2,
    RST_HOLD    = 3'd3,
    READY       = 3'd4,
    RAIL_OFF    = 3'd5,
    FAULT       = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RAILS-1:0] rail_en, rail_en_nxt;
  logic             cam_pwdn, cam_pwdn_nxt;
  logic             cam_rst_n, cam_rst_n_nxt;
  logic             ready, ready_nxt;
  logic             fault, fault_nxt;
  logic             go_fault, go_off;
  logic             pg_cur, pg_tmo, pg_loss;

`ifdef CAM_PWR_SEQ_PG_CHECK_EN
  localparam logic [CNT_W-1:0] TMO_LAST = (TMO_T > 0) ? CNT_W'(TMO_T - 1) : '0;
  logic [RAILS-1:0] settled;

  // Rails whose settle delay has completed are the ones supervised for PG loss.
  always_comb begin
    settled = '0;
    for (int k = 0; k < RAILS; k++) begin
      if (state == RST_HOLD || state == READY)
        settled[k] = 1'b1;
      else if (state == RAIL_SETTLE && k < int'(idx))
        settled[k] = 1'b1;
    end
  end

  assign pg_cur  = pg_i[idx];
  assign pg_tmo  = (cnt == TMO_LAST);
  assign pg_loss = |(settled & rail_en & ~pg_i);
`else
  logic unused_pg;
  assign unused_pg = ^pg_i;
  assign pg_cur  = 1'b1;
  assign pg_tmo  = 1'b0;
  assign pg_loss = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    rail_en_nxt   = rail_en;
    cam_pwdn_nxt  = cam_pwdn;
    cam_rst_n_nxt = cam_rst_n;
    ready_nxt     = ready;
    fault_nxt     = fault;
    go_fault      = 1'b0;
    go_off        = 1'b0;

    case (state)
      IDLE: begin
        if (en_i) begin
          state_nxt      = RAIL_ON;
          idx_nxt        = '0;
          cnt_nxt        = '0;
          rail_en_nxt[0] = 1'b1;
        end
      end
      RAIL_ON: begin
        // PG arriving on the timeout cycle still counts as good.
        if (pg_tmo && !pg_cur)  go_fault = 1'b1;
        else if (!en_i)         go_off   = 1'b1;
        else if (pg_cur) begin
          state_nxt = RAIL_SETTLE;
          cnt_nxt   = '0;
        end else                cnt_nxt  = cnt + 1'b1;
      end
      RAIL_SETTLE: begin
        if (pg_loss)            go_fault = 1'b1;
        else if (!en_i)         go_off   = 1'b1;
        else if (cnt == STEP_LAST) begin
          cnt_nxt = '0;
          if (idx == LAST_IDX) begin
            state_nxt    = RST_HOLD;
            cam_pwdn_nxt = 1'b0;
          end else begin
            state_nxt            = RAIL_ON;
            idx_nxt              = idx + 1'b1;
            rail_en_nxt[idx_nxt] = 1'b1;
          end
        end else                cnt_nxt  = cnt + 1'b1;
      end
      RST_HOLD: begin
        if (pg_loss)            go_fault = 1'b1;
        else if (!en_i)         go_off   = 1'b1;
        else if (cnt == HOLD_LAST) begin
          state_nxt     = READY;
          cam_rst_n_nxt = 1'b1;
          ready_nxt     = 1'b1;
          cnt_nxt       = '0;
        end else                cnt_nxt  = cnt + 1'b1;
      end
      READY: begin
        if (pg_loss)            go_fault = 1'b1;
        else if (!en_i)         go_off   = 1'b1;
      end
      RAIL_OFF: begin
        // idx holds the rail cleared most recently; en_i is ignored until IDLE.
        if (cnt == STEP_LAST) begin
          cnt_nxt              = '0;
          idx_nxt              = idx - 1'b1;
          rail_en_nxt[idx_nxt] = 1'b0;
          if (idx_nxt == '0) state_nxt = IDLE;
        end else                cnt_nxt  = cnt + 1'b1;
      end
      FAULT: begin
        if (!en_i) begin
          state_nxt = IDLE;
          fault_nxt = 1'b0;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (go_fault) begin
      state_nxt     = FAULT;
      rail_en_nxt   = '0;
      cam_pwdn_nxt  = 1'b1;
      cam_rst_n_nxt = 1'b0;
      ready_nxt     = 1'b0;
      fault_nxt     = 1'b1;
      cnt_nxt       = '0;
    end else if (go_off) begin
      // The highest enabled rail is idx; it clears on the entry edge.
      state_nxt        = (idx == '0) ? IDLE : RAIL_OFF;
      rail_en_nxt[idx] = 1'b0;
      cam_pwdn_nxt     = 1'b1;
      cam_rst_n_nxt    = 1'b0;
      ready_nxt        = 1'b0;
      cnt_nxt          = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      rail_en   <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      rail_en   <= rail_en_nxt;
      cam_pwdn  <= cam_pwdn_nxt;
      cam_rst_n <= cam_rst_n_nxt;
      ready     <= ready_nxt;
      fault     <= fault_nxt;
    end
  end

  assign rail_en_o   = rail_en;
  assign cam_pwdn_o  = cam_pwdn;
  assign cam_rst_n_o = cam_rst_n;
  assign ready_o     = ready;
  assign fault_o     = fault;
  assign state_o     = state;

endmodule
